// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_arb_pkg;

  // Widest master index needed for up to 8 masters.
  localparam int unsigned MAX_ID_W = 3;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } rd_tag_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/response and memory-bus signals of the arbiter.
interface mem_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        lock_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]        wr_en_i;
  logic [NUM_REQ*DATA_W-1:0] wr_data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        rd_valid_o;
  logic [DATA_W-1:0]         rd_data_o;
  logic [ADDR_W-1:0]         bus_addr_o;
  logic [DATA_W-1:0]         bus_wr_data_o;
  logic                      bus_wr_en_o;
  logic [DATA_W-1:0]         bus_rd_data_i;

  modport master (
    output req_i, lock_i, addr_i, wr_en_i, wr_data_i, bus_rd_data_i,
    input  gnt_o, rd_valid_o, rd_data_o, bus_addr_o, bus_wr_data_o, bus_wr_en_o
  );

  modport slave (
    input  req_i, lock_i, addr_i, wr_en_i, wr_data_i, bus_rd_data_i,
    output gnt_o, rd_valid_o, rd_data_o, bus_addr_o, bus_wr_data_o, bus_wr_en_o
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after the last winner.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin data-memory bus arbiter with read-return routing.
// Optional bounded burst lock enabled by defining MEM_ARB_LOCK_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_LOCK     = 8
) (
  input logic              clk_i,
  input logic              reset_ni,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]    last_q;
  logic [ID_W-1:0]    rr_idx;
  logic [ID_W-1:0]    g_idx;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt_c;
  logic               rr_valid;
  logic               g_valid;
  logic               beat;
  rd_tag_t            push_tag;
  rd_tag_t            ret_tag;

  rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_picker (
    .req   (bus.req_i),
    .last  (last_q),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  lock_state_e      state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_beat;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Owner keeps the bus while it requests; any other beat may start a new lock.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    owner_beat = (state_q == LOCKED) && bus.req_i[owner_q];
    g_idx      = rr_idx;
    g_valid    = rr_valid;
    gnt_c      = rr_gnt;
    if (owner_beat) begin
      g_idx          = owner_q;
      g_valid        = 1'b1;
      gnt_c          = '0;
      gnt_c[owner_q] = 1'b1;
      if (bus.lock_i[owner_q] && (32'(cnt_q) < MAX_LOCK - 1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    end else if (rr_valid && bus.lock_i[rr_idx] && (MAX_LOCK > 1)) begin
      state_d = LOCKED;
      owner_d = rr_idx;
      cnt_d   = CNT_W'(1);
    end else begin
      state_d = UNLOCKED;
      cnt_d   = '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock_i;
  assign g_idx       = rr_idx;
  assign g_valid     = rr_valid;
  assign gnt_c       = rr_gnt;
`endif

  assign beat      = reset_ni && g_valid;
  assign bus.gnt_o = reset_ni ? gnt_c : '0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)  last_q <= ID_W'(NUM_REQ - 1);
    else if (beat)  last_q <= g_idx;
  end

  // Granted master drives the bus; nothing is driven without a grant.
  always_comb begin
    bus.bus_addr_o    = '0;
    bus.bus_wr_data_o = '0;
    bus.bus_wr_en_o   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (beat && (g_idx == ID_W'(i))) begin
        bus.bus_addr_o    = bus.addr_i[i*ADDR_W +: ADDR_W];
        bus.bus_wr_data_o = bus.wr_data_i[i*DATA_W +: DATA_W];
        bus.bus_wr_en_o   = bus.wr_en_i[i];
      end
    end
  end

  assign bus.rd_data_o = bus.bus_rd_data_i;

  always_comb begin
    push_tag = '0;
    if (beat) begin
      push_tag.valid = ~bus.wr_en_i[g_idx];
      push_tag.id    = MAX_ID_W'(g_idx);
    end
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign ret_tag = push_tag;
  end else begin : g_pipe
    rd_tag_t pipe_q [READ_LATENCY];

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= push_tag;
        for (int unsigned i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign ret_tag = pipe_q[READ_LATENCY-1];
  end

  always_comb begin
    bus.rd_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      bus.rd_valid_o[i] = ret_tag.valid && (ret_tag.id == MAX_ID_W'(i));
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NUM_REQ      = 2;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned READ_LATENCY = 1;
  localparam int unsigned MAX_LOCK     = 8;
  localparam int          NV           = 13;

  logic clk_i = 1'b0;
  logic reset_ni;
  always #5 clk_i = ~clk_i;

  mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_LATENCY(READ_LATENCY), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] gnt;
    logic       we;
    logic [1:0] rdv;
  } vec_t;

  vec_t        tab [NV];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic [31:0] rd_word;

  // Reference model state
  int  m_last;
  bit  m_lock;
  int  m_owner;
  int  m_run;
  int  m_rdq[$];

  function automatic vec_t mk(logic [1:0] req, logic [1:0] wr, logic [1:0] gnt,
                              logic we, logic [1:0] rdv);
    vec_t v;
    v.req = req; v.wr = wr; v.gnt = gnt; v.we = we; v.rdv = rdv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] wr);
    bus.req_i         = req;
    bus.lock_i        = lock;
    bus.wr_en_i       = wr;
    bus.addr_i        = {a[1], a[0]};
    bus.wr_data_i     = {d[1], d[0]};
    rd_word           = $urandom;
    bus.bus_rd_data_i = rd_word;
  endtask

  task automatic check_cycle(input string tag, input logic [1:0] eg, input logic ewe,
                             input logic [1:0] erv);
    logic [31:0] ea;
    logic [31:0] ed;
    ea = eg[0] ? a[0] : (eg[1] ? a[1] : 32'h0);
    ed = eg[0] ? d[0] : (eg[1] ? d[1] : 32'h0);
    chk({tag, ".gnt"},      64'(bus.gnt_o),         64'(eg));
    chk({tag, ".wr_en"},    64'(bus.bus_wr_en_o),   64'(ewe));
    chk({tag, ".addr"},     64'(bus.bus_addr_o),    64'(ea));
    chk({tag, ".wdata"},    64'(bus.bus_wr_data_o), 64'(ed));
    chk({tag, ".rd_valid"}, 64'(bus.rd_valid_o),    64'(erv));
    chk({tag, ".rd_data"},  64'(bus.rd_data_o),     64'(rd_word));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_ni = 1'b0;
    drive(2'b00, 2'b00, 2'b00);
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  function automatic void model_reset();
    m_last = NUM_REQ - 1;
    m_lock = 1'b0;
    m_owner = 0;
    m_run = 0;
    m_rdq = {};
    for (int i = 0; i < int'(READ_LATENCY); i++) m_rdq.push_back(-1);
  endfunction

  function automatic int model_pick(input logic [1:0] req);
    if (m_lock && req[m_owner]) return m_owner;
    for (int k = 1; k <= int'(NUM_REQ); k++)
      if (req[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic void model_commit(input logic [1:0] req, input logic [1:0] lock,
                                       input logic [1:0] wr, input int g);
`ifdef MEM_ARB_LOCK_EN
    if (m_lock && req[m_owner]) begin
      if (lock[m_owner]) begin
        m_run++;
        if (m_run >= int'(MAX_LOCK)) m_lock = 1'b0;
      end else begin
        m_lock = 1'b0;
      end
    end else if (g >= 0 && lock[g] && MAX_LOCK > 1) begin
      m_lock = 1'b1; m_owner = g; m_run = 1;
    end else begin
      m_lock = 1'b0;
    end
`endif
    if (g >= 0) m_last = g;
    m_rdq.push_back((g >= 0 && !wr[g]) ? g : -1);
    void'(m_rdq.pop_front());
  endfunction

  initial begin
    tab[0]  = mk(2'b11, 2'b00, 2'b01, 1'b0, 2'b00);
    tab[1]  = mk(2'b11, 2'b00, 2'b10, 1'b0, 2'b01);
    tab[2]  = mk(2'b11, 2'b00, 2'b01, 1'b0, 2'b10);
    tab[3]  = mk(2'b10, 2'b10, 2'b10, 1'b1, 2'b01);
    tab[4]  = mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    tab[5]  = mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b00);
    tab[6]  = mk(2'b10, 2'b00, 2'b10, 1'b0, 2'b00);
    tab[7]  = mk(2'b10, 2'b00, 2'b10, 1'b0, 2'b10);
    tab[8]  = mk(2'b01, 2'b01, 2'b01, 1'b1, 2'b10);
    tab[9]  = mk(2'b11, 2'b00, 2'b10, 1'b0, 2'b00);
    tab[10] = mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b10);
    tab[11] = mk(2'b01, 2'b00, 2'b01, 1'b0, 2'b00);
    tab[12] = mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b01);

    a[0] = 32'h40; a[1] = 32'h100;
    d[0] = 32'hC0DE0000; d[1] = 32'hDEADBEEF;

    // Outputs held quiet during reset even with requests pending
    reset_ni = 1'b0;
    drive(2'b11, 2'b11, 2'b11);
    #1;
    check_cycle("reset", 2'b00, 1'b0, 2'b00);
    @(negedge clk_i);
    drive(2'b00, 2'b00, 2'b00);
    reset_ni = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk_i);
      a[0] = 32'h40 + 32'(k);
      d[0] = 32'hC0DE0000 + 32'(k);
      drive(tab[k].req, 2'b00, tab[k].wr);
      #1;
      check_cycle($sformatf("vec%0d", k), tab[k].gnt, tab[k].we, tab[k].rdv);
    end

`ifdef MEM_ARB_LOCK_EN
    // Master 0 holds lock: MAX_LOCK beats, then master 1
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_i);
      drive(2'b11, 2'b01, 2'b00);
      #1;
      chk($sformatf("lockmax%0d.gnt", c), 64'(bus.gnt_o), (c < 8) ? 64'h1 : 64'h2);
    end
    // Master 0 drops lock on its third beat
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      drive(2'b11, (c == 2) ? 2'b00 : 2'b01, 2'b00);
      #1;
      chk($sformatf("lockdrop%0d.gnt", c), 64'(bus.gnt_o), (c < 3) ? 64'h1 : 64'h2);
    end
`endif

    // Reset during a granted read of master 1 drops its response
    do_reset();
    @(negedge clk_i);
    drive(2'b01, 2'b00, 2'b00);
    #1;
    chk("rstrd.first.gnt", 64'(bus.gnt_o), 64'h1);
    @(negedge clk_i);
    drive(2'b10, 2'b00, 2'b00);
    #1;
    chk("rstrd.m1.gnt", 64'(bus.gnt_o), 64'h2);
    chk("rstrd.m0.rdv", 64'(bus.rd_valid_o), 64'h1);
    reset_ni = 1'b0;
    #1;
    chk("rstrd.inrst.gnt", 64'(bus.gnt_o), 64'h0);
    chk("rstrd.inrst.rdv", 64'(bus.rd_valid_o), 64'h0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    drive(2'b11, 2'b00, 2'b00);
    #1;
    chk("rstrd.after.gnt", 64'(bus.gnt_o), 64'h1);
    chk("rstrd.after.rdv", 64'(bus.rd_valid_o), 64'h0);
    @(negedge clk_i);
    drive(2'b00, 2'b00, 2'b00);
    #1;
    chk("rstrd.next.rdv", 64'(bus.rd_valid_o), 64'h1);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [1:0] req, lock, wr, eg, erv;
      int         g;
      logic       ewe;
      @(negedge clk_i);
      req  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
      lock = 2'($urandom);
      wr   = 2'($urandom);
      a[0] = $urandom; a[1] = $urandom;
      d[0] = $urandom; d[1] = $urandom;
      drive(req, lock, wr);
      g   = model_pick(req);
      eg  = (g >= 0) ? 2'(1 << g) : 2'b00;
      ewe = (g >= 0) ? wr[g] : 1'b0;
      erv = (m_rdq[0] >= 0) ? 2'(1 << m_rdq[0]) : 2'b00;
      #1;
      check_cycle($sformatf("rnd%0d", n), eg, ewe, erv);
      model_commit(req, lock, wr, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
